// File: rtl/tpram64x288_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tpram64x288_fifo_ctrl
//   Streaming FIFO controller driving one 64x288 two-port RAM wrapper
//   (active-low enables, 1-cycle registered read). It converts valid/ready
//   write and read streams into RAM accesses. A 2-entry output buffer absorbs
//   the RAM read latency, so total capacity is DEPTH + 2 beats.
//
//   Build option: define TPRAM_FIFO_RD_PRIO_EN for single-port ASIC macros.
//   Reads then take priority and a write is never issued in the same cycle as
//   a read. With the macro undefined, writes and reads run independently.
//
// Ports
//   i_clk        clock (RAM read and write clocks are driven from it)
//   i_rst        synchronous active-high reset
//   i_in_valid   write-stream valid
//   o_in_ready   write-stream ready (independent of i_in_valid)
//   i_in_data    write-stream data
//   o_out_valid  read-stream valid
//   i_out_ready  read-stream ready
//   o_out_data   read-stream data, head of the FIFO
//   o_ram_wceb   RAM write enable, active-low
//   o_ram_waddr  RAM write address
//   o_ram_wdata  RAM write data (i_in_data)
//   o_ram_rceb   RAM read enable, active-low
//   o_ram_raddr  RAM read address
//   i_ram_rdata  RAM read data, valid 1 cycle after o_ram_rceb low
//   o_level      entries in RAM that have not been read-issued, 0..DEPTH
// ---------------------------------------------------------------------------
module tpram64x288_fifo_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 288
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_in_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_data,
  output logic          o_ram_wceb,
  output logic [AW-1:0] o_ram_waddr,
  output logic [DW-1:0] o_ram_wdata,
  output logic          o_ram_rceb,
  output logic [AW-1:0] o_ram_raddr,
  input  logic [DW-1:0] i_ram_rdata,
  output logic [AW:0]   o_level
);

  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_ram_cnt;
  logic                 r_rd_inflight;
  logic [1:0][DW-1:0]   r_ob;       // r_ob[0] is the oldest entry
  logic [1:0]           r_ob_cnt;

  logic                 w_pop;
  logic                 w_rd_issue;
  logic                 w_wr_fire;
  logic                 w_not_full;
  logic [2:0]           w_occ;
  logic [1:0]           w_ob_wpos;

  assign w_pop = o_out_valid & i_out_ready;

  // Slots the output buffer will need once this cycle's pop is taken out:
  // current entries plus the read already in flight. A new read may only be
  // issued when a slot will be free for it two cycles from now.
  assign w_occ      = {1'b0, r_ob_cnt} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
  assign w_rd_issue = ~i_rst & (r_ram_cnt != '0) & (w_occ < 3'd2);
  assign w_not_full = (r_ram_cnt < (AW+1)'(DEPTH));

`ifdef TPRAM_FIFO_RD_PRIO_EN
  // Single-port macro: a pending read blocks the write port this cycle.
  assign o_in_ready = ~i_rst & w_not_full & ~w_rd_issue;
`else
  assign o_in_ready = ~i_rst & w_not_full;
`endif

  assign w_wr_fire = i_in_valid & o_in_ready;

  // Returning read data lands behind whatever survives this cycle's pop.
  assign w_ob_wpos = r_ob_cnt - {1'b0, w_pop};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ram_cnt     <= '0;
      r_rd_inflight <= 1'b0;   // read data arriving after reset is dropped
      r_ob          <= '0;
      r_ob_cnt      <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_ram_cnt     <= r_ram_cnt + (AW+1)'(w_wr_fire) - (AW+1)'(w_rd_issue);
      r_rd_inflight <= w_rd_issue;
      if (w_pop) r_ob[0] <= r_ob[1];
      // Placed after the shift so a push into slot 0 overrides it.
      if (r_rd_inflight) r_ob[w_ob_wpos[0]] <= i_ram_rdata;
      r_ob_cnt <= r_ob_cnt + {1'b0, r_rd_inflight} - {1'b0, w_pop};
    end
  end

  assign o_out_valid = (r_ob_cnt != 2'd0);
  assign o_out_data  = r_ob[0];
  assign o_ram_wceb  = ~w_wr_fire;
  assign o_ram_waddr = r_wr_ptr;
  assign o_ram_wdata = i_in_data;
  assign o_ram_rceb  = ~w_rd_issue;
  assign o_ram_raddr = r_rd_ptr;
  assign o_level     = r_ram_cnt;

endmodule

// File: tb/tb_tpram64x288_fifo_ctrl.sv
module tb_tpram64x288_fifo_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 288;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          wceb, rceb;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic [AW:0]   level;

  always #5 clk = ~clk;

  tpram64x288_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_ram_wceb(wceb), .o_ram_waddr(waddr), .o_ram_wdata(wdata),
    .o_ram_rceb(rceb), .o_ram_raddr(raddr), .i_ram_rdata(rdata),
    .o_level(level)
  );

  // Two-port RAM model with registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!rceb) rdata <= mem[raddr];
    if (!wceb) mem[waddr] <= wdata;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] sbq[$];

  // Per-cycle sample, taken mid-low-phase before the edge that commits it.
  logic          t_wfire, t_pop, t_uf, t_inrdy, t_col, t_rceb;
  logic [DW-1:0] t_exp, t_act;
  logic [AW:0]   t_lvl;

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] w;
    w = k;
    return {9{w}};
  endfunction

  task automatic tick();
    #2;
    t_inrdy = in_ready;
    t_wfire = in_valid & in_ready;
    t_pop   = out_valid & out_ready;
    t_act   = out_data;
    t_col   = !wceb && !rceb;
    t_rceb  = rceb;
    t_lvl   = level;
    t_uf    = 1'b0;
    t_exp   = '0;
    if (t_pop) begin
      if (sbq.size() == 0) t_uf = 1'b1;
      else t_exp = sbq.pop_front();
    end
    if (t_wfire) sbq.push_back(in_data);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (wceb !== 1'b1) begin n_err++; $display("FAIL rst_wceb got %b exp 1", wceb); end
    n_cmp++; if (rceb !== 1'b1) begin n_err++; $display("FAIL rst_rceb got %b exp 1", rceb); end
    n_cmp++; if (waddr !== '0) begin n_err++; $display("FAIL rst_waddr got %0d exp 0", waddr); end
    n_cmp++; if (raddr !== '0) begin n_err++; $display("FAIL rst_raddr got %0d exp 0", raddr); end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL rst_level got %0d exp 0", level); end
    rst = 1'b0;
    tick();
    n_cmp++; if (t_inrdy !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b exp 1", t_inrdy); end
  endtask

  task automatic test_single();
    int lat;
    in_valid = 1'b1; in_data = 288'h1; out_ready = 1'b1;
    tick();
    n_cmp++; if (t_wfire !== 1'b1) begin n_err++; $display("FAIL single_accept got %b exp 1", t_wfire); end
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick();
      if (t_pop) begin
        lat = i;
        n_cmp++; if (t_uf || t_act !== t_exp) begin n_err++; $display("FAIL single_data got %h exp %h", t_act, t_exp); end
      end
    end
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL single_latency got %0d exp 3", lat); end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL single_level got %0d exp 0", level); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    int k, idle, n;
    logic [AW-1:0] w0;
    w0 = waddr;
    in_valid = 1'b1; out_ready = 1'b0; k = 0; idle = 0;
    for (int i = 0; i < 300 && idle < 4; i++) begin
      in_data = pat(k);
      tick();
      if (t_wfire) begin k++; idle = 0; end else idle++;
    end
    in_valid = 1'b0;
    n_cmp++; if (k != DEPTH + 2) begin n_err++; $display("FAIL fill_count got %0d exp %0d", k, DEPTH + 2); end
    n_cmp++; if (level !== 7'd64) begin n_err++; $display("FAIL fill_level got %0d exp 64", level); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %b exp 0", in_ready); end
    n_cmp++; if (waddr !== AW'(w0 + 6'd2)) begin n_err++; $display("FAIL fill_wptr got %0d exp %0d", waddr, AW'(w0 + 6'd2)); end
    out_ready = 1'b1; n = 0;
    for (int i = 0; i < 400 && n < DEPTH + 2; i++) begin
      tick();
      if (t_pop) begin
        n++;
        n_cmp++; if (t_uf || t_act !== t_exp) begin n_err++; $display("FAIL drain_data got %h exp %h", t_act, t_exp); end
      end
    end
    n_cmp++; if (n != DEPTH + 2) begin n_err++; $display("FAIL drain_count got %0d exp %0d", n, DEPTH + 2); end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL drain_level got %0d exp 0", level); end
    n_cmp++; if (raddr !== waddr) begin n_err++; $display("FAIL drain_rptr got %0d exp %0d", raddr, waddr); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc, pops, stall, col, first, last;
    acc = 0; pops = 0; stall = 0; col = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 2000 && pops < 200; i++) begin
      in_valid = (acc < 200);
      in_data  = pat(1000 + acc);
      tick();
      if (pops > 0 && acc < 200 && !t_inrdy) stall++;
      if (t_col) col++;
      if (t_wfire) acc++;
      if (t_pop) begin
        if (first < 0) first = i;
        last = i;
        pops++;
        n_cmp++; if (t_uf || t_act !== t_exp) begin n_err++; $display("FAIL stream_data got %h exp %h", t_act, t_exp); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (pops != 200) begin n_err++; $display("FAIL stream_count got %0d exp 200", pops); end
`ifdef TPRAM_FIFO_RD_PRIO_EN
    n_cmp++; if (col != 0) begin n_err++; $display("FAIL stream_port_collide got %0d exp 0", col); end
`else
    n_cmp++; if (stall != 0) begin n_err++; $display("FAIL stream_stall got %0d exp 0", stall); end
    n_cmp++; if (last - first != 199) begin n_err++; $display("FAIL stream_rate got %0d exp 199", last - first); end
`endif
  endtask

  task automatic test_random();
    int acc, pops, viol;
    acc = 0; pops = 0; viol = 0;
    for (int i = 0; i < 80000 && pops < 10000; i++) begin
      in_valid  = (acc < 10000) && ($urandom_range(1) == 1);
      out_ready = ($urandom_range(1) == 1);
      in_data   = {9{$urandom}};
      tick();
      if (t_lvl > 7'd64 || (t_wfire && t_lvl == 7'd64)) viol++;
      if (t_wfire) acc++;
      if (t_pop) begin
        pops++;
        n_cmp++; if (t_uf || t_act !== t_exp) begin n_err++; $display("FAIL rand_data got %h exp %h", t_act, t_exp); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (pops != 10000) begin n_err++; $display("FAIL rand_count got %0d exp 10000", pops); end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL rand_level_viol got %0d exp 0", viol); end
  endtask

  task automatic test_reset_mid();
    int acc, got, extra;
    acc = 0;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 50 && acc < 5; i++) begin
      in_data = pat(5000 + acc);
      tick();
      if (t_wfire) acc++;
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    // One pop with the buffer full issues a read, leaving it in flight.
    out_ready = 1'b1;
    tick();
    n_cmp++; if (t_pop !== 1'b1 || t_uf || t_act !== t_exp) begin n_err++; $display("FAIL midrst_pop got %h exp %h", t_act, t_exp); end
    n_cmp++; if (t_rceb !== 1'b0) begin n_err++; $display("FAIL midrst_issue got %b exp 0", t_rceb); end
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    sbq.delete();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL midrst_level got %0d exp 0", level); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale got %b exp 0", out_valid); end
    in_valid = 1'b1; in_data = pat(32'hABC); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    got = 0; extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (t_pop) begin
        if (got == 0) begin
          n_cmp++; if (t_uf || t_act !== pat(32'hABC)) begin n_err++; $display("FAIL midrst_next got %h exp %h", t_act, pat(32'hABC)); end
        end else extra++;
        got++;
      end
    end
    n_cmp++; if (got != 1) begin n_err++; $display("FAIL midrst_pops got %0d exp 1 (extra %0d)", got, extra); end
    out_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
